// File: rtl/div_issuer.sv
// Purpose : in-order request sequencer feeding one shared fixed-point divider.
// Latency : push to response = divider latency + 3 cycles (empty FIFO, divider idle).
// Backpressure: req_ready = !full; a held response (rsp_ready=0) stalls issue while the FIFO fills.
//
// Ports
//   clk, reset                      : clock, synchronous active-high reset (shared with divider)
//   req_valid/req_ready             : request stream, payload req_dividend, req_divisor, req_tag
//   rsp_valid/rsp_ready             : response stream, payload rsp_quotient, rsp_tag,
//                                     rsp_div_by_zero, rsp_timeout
//   div_start/div_ready/div_valid   : divider handshake; div_dividend/div_divisor out, div_quotient in
//   busy                            : any request queued, in flight, or awaiting consumption

`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif

// Purpose : generic in-order FIFO, power-of-two depth, count register separates full/empty.
// Latency : data pushed at edge N is visible on pop_dat from N (fall-through head).
// Backpressure: push_rdy = !full; a pop in the same cycle does not free a slot for a push.
module div_issuer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (count != CW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_rdy && pop_vld;
  assign pop_dat  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

module div_issuer #(
  parameter int WIDTH   = `WIDTH,
  parameter int Q_BITS  = `Q_BITS,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_div_by_zero,
  output logic             rsp_timeout,
  output logic             div_start,
  input  logic             div_ready,
  input  logic             div_valid,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  output logic             busy
);

  // Reject configurations the pointer arithmetic and the divider cannot support.
  if (Q_BITS >= WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("div_issuer: illegal parameter combination");
  end

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  req_t             push_dat;
  req_t             head_dat;
  logic             fifo_vld;
  logic             fifo_rdy;
  logic             slot_free;
  logic             issue_go;
  logic             done_ok;
  logic             done_to;
  logic [TAG_W-1:0] cur_tag;
  logic [TO_W-1:0]  to_cnt;

  assign push_dat = '{tag: req_tag, dividend: req_dividend, divisor: req_divisor};

  div_issuer_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (req_valid),
    .push_rdy (fifo_rdy),
    .push_dat (push_dat),
    .pop_vld  (fifo_vld),
    .pop_rdy  (issue_go),
    .pop_dat  (head_dat)
  );

  assign req_ready = fifo_rdy;

  // The response register is free this cycle if empty or being drained now;
  // this keeps back-to-back issue one cycle behind each capture.
  assign slot_free = !rsp_valid || rsp_ready;

  assign busy = fifo_vld || (state != S_IDLE) || rsp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue_go  = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_vld && div_ready && slot_free) begin
          issue_go  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last permitted cycle still wins over timeout.
        if (div_valid) begin
          done_ok   = 1'b1;
          state_nxt = S_IDLE;
        end else if (to_cnt == TO_LAST) begin
          done_to   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Issue path: operands are loaded only on pop and held untouched until the
  // next pop, because the divider forms the result sign from its live inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      cur_tag      <= '0;
      to_cnt       <= '0;
    end else begin
      div_start <= issue_go;
      if (issue_go) begin
        div_dividend <= head_dat.dividend;
        div_divisor  <= head_dat.divisor;
        cur_tag      <= head_dat.tag;
      end
      if (state == S_ISSUE) begin
        to_cnt <= '0;
      end else if (state == S_WAIT) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Response register. div_valid outside S_WAIT never reaches done_ok, so a
  // late result from an abandoned operation is dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid       <= 1'b0;
      rsp_quotient    <= '0;
      rsp_tag         <= '0;
      rsp_div_by_zero <= 1'b0;
      rsp_timeout     <= 1'b0;
    end else if (done_ok) begin
      rsp_valid       <= 1'b1;
      rsp_quotient    <= div_quotient;
      rsp_tag         <= cur_tag;
      rsp_div_by_zero <= (div_divisor == '0);
      rsp_timeout     <= 1'b0;
    end else if (done_to) begin
      rsp_valid       <= 1'b1;
      rsp_quotient    <= '0;
      rsp_tag         <= cur_tag;
      rsp_div_by_zero <= 1'b0;
      rsp_timeout     <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
